// File: rtl/spi_sort_pkg.sv
// Shared opcodes, FSM states and status-frame bit positions for the SPI sort bridge.
// Constants only: no logic, so no latency and no flow control.
package spi_sort_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;
  localparam logic [7:0] OP_CLEAR  = 8'h04;

  typedef enum logic [2:0] {
    IDLE, CMD, WR_COLLECT, RD_STREAM, STAT, CLR_WAIT, DISCARD
  } state_e;

  localparam int STAT_OVF_BIT   = 7;
  localparam int STAT_UDF_BIT   = 6;
  localparam int STAT_FULL_BIT  = 5;
  localparam int STAT_EMPTY_BIT = 4;

endpackage

// File: rtl/fast_serial_sort.sv
// Insertion-sorted buffer, smallest word always on sorted_data; enable+write inserts, enable alone pops.
// One-cycle update; no backpressure (caller must not insert when full or pop when empty).
module fast_serial_sort #(
  parameter int DATA_WIDTH = 16,
  parameter int SIZE       = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] sorted_data
);

  logic [DATA_WIDTH-1:0] mem_q [SIZE];
  logic [DATA_WIDTH-1:0] mem_d [SIZE];
  logic [SIZE-1:0]       vld_q, vld_d, gt;

  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    for (int i = 0; i < SIZE; i++) gt[i] = !vld_q[i] || (mem_q[i] > data_in);
    if (enable && write) begin
      if (gt[0]) begin
        mem_d[0] = data_in;
        vld_d[0] = 1'b1;
      end
      for (int i = 1; i < SIZE; i++) begin
        if (gt[i] && !gt[i-1]) begin
          mem_d[i] = data_in;
          vld_d[i] = 1'b1;
        end else if (gt[i]) begin
          mem_d[i] = mem_q[i-1];
          vld_d[i] = vld_q[i-1];
        end
      end
    end else if (enable) begin
      for (int i = 0; i < SIZE - 1; i++) begin
        mem_d[i] = mem_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      mem_d[SIZE-1] = '0;
      vld_d[SIZE-1] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE; i++) mem_q[i] <= '0;
      vld_q <= '0;
    end else begin
      mem_q <= mem_d;
      vld_q <= vld_d;
    end
  end

  assign sorted_data = vld_q[0] ? mem_q[0] : '0;

endmodule

// File: rtl/spi_slave_interface.sv
// SPI mode-0 slave oversampled in clk; one frame per cs-low window segment, MSB first.
// Frame flag rises ~3 clk after the last sck edge and holds until cleared; no backpressure.
module spi_slave_interface #(
  parameter int FRAME_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sck,
  input  logic                   mosi,
  input  logic                   cs,
  input  logic [FRAME_WIDTH-1:0] data_to_send,
  input  logic                   clear_new_data_flag,
  output logic                   miso,
  output logic [FRAME_WIDTH-1:0] data_received,
  output logic                   synced_new_data_flag
);

  localparam int BCW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_WIDTH - 1);

  logic [2:0]             sck_q;
  logic [1:0]             mosi_q;
  logic [1:0]             cs_q;
  logic [BCW-1:0]         bit_cnt_q;
  logic [FRAME_WIDTH-1:0] rx_shift_q, rx_data_q, tx_shift_q;
  logic                   flag_q;
  logic                   sck_rise, sck_fall;
  logic [FRAME_WIDTH-1:0] rx_next;

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign rx_next  = FRAME_WIDTH'({rx_shift_q, mosi_q[1]});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_q      <= '0;
      mosi_q     <= '0;
      cs_q       <= '1;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_shift_q <= '0;
      flag_q     <= 1'b0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      mosi_q <= {mosi_q[0], mosi};
      cs_q   <= {cs_q[0], cs};
      if (clear_new_data_flag) flag_q <= 1'b0;
      if (cs_q[1]) begin
        bit_cnt_q <= '0;
      end else if (sck_rise) begin
        rx_shift_q <= rx_next;
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_q <= '0;
          rx_data_q <= rx_next;
          flag_q    <= 1'b1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
      // Between frames the shifter tracks data_to_send so a late-updated reply still goes out.
      if (bit_cnt_q == '0) tx_shift_q <= data_to_send;
      else if (sck_fall)   tx_shift_q <= tx_shift_q << 1;
    end
  end

  assign miso                 = tx_shift_q[FRAME_WIDTH-1];
  assign data_received        = rx_data_q;
  assign synced_new_data_flag = flag_q;

endmodule

// File: rtl/spi_sort_bridge.sv
// Opcode-driven SPI front end for the sorter: multi-frame words, read stream, status, clear.
// Sorter enable one clk after the completing frame; SPI has no backpressure, so full/empty set sticky flags.
module spi_sort_bridge
  import spi_sort_pkg::*;
#(
  parameter int FRAME_WIDTH = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int SIZE        = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs,
  output logic       miso,
  output logic [7:0] word_count,
  output logic       overflow,
  output logic       underflow
);

  localparam int BPW = DATA_WIDTH / FRAME_WIDTH;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BIW-1:0] LAST_IDX = BIW'(BPW - 1);
  localparam logic [7:0]     SIZE_C   = 8'(SIZE);

  state_e                 state_q, state_d;
  logic [BIW-1:0]         byte_idx_q, byte_idx_d;
  logic [DATA_WIDTH-1:0]  word_q, word_d, tx_word_q, tx_word_d, byte_shift;
  logic [FRAME_WIDTH-1:0] tx_frame_q, tx_frame_d, rx_data, status_frame;
  logic [7:0]             count_q, count_d;
  logic [1:0]             stat_idx_q, stat_idx_d;
  logic                   ovf_q, ovf_d, udf_q, udf_d;
  logic                   en_q, en_d, wr_q, wr_d, clr_q, clr_d;
  logic                   cs_meta_q, cs_s_q, cs_prev_q, flag_q;
  logic                   new_flag, frame_pulse, cs_fall, cs_rise, do_fetch;
  logic [DATA_WIDTH-1:0]  sorted_data;

  spi_slave_interface #(.FRAME_WIDTH(FRAME_WIDTH)) u_spi (
    .clk                 (clk),
    .reset               (reset),
    .sck                 (sck),
    .mosi                (mosi),
    .cs                  (cs),
    .data_to_send        (tx_frame_q),
    .clear_new_data_flag (flag_q),
    .miso                (miso),
    .data_received       (rx_data),
    .synced_new_data_flag(new_flag)
  );

  // CLEAR resets the sorter contents through a one-clk registered pulse.
  fast_serial_sort #(.DATA_WIDTH(DATA_WIDTH), .SIZE(SIZE)) u_sort (
    .clk        (clk),
    .reset      (reset | clr_q),
    .enable     (en_q),
    .write      (wr_q),
    .data_in    (word_q),
    .sorted_data(sorted_data)
  );

  assign frame_pulse = new_flag & ~flag_q;
  assign cs_fall     = cs_prev_q & ~cs_s_q;
  assign cs_rise     = ~cs_prev_q & cs_s_q;
  assign byte_shift  = tx_word_q << ((int'(byte_idx_q) + 1) * FRAME_WIDTH);

  always_comb begin
    status_frame                 = '0;
    status_frame[STAT_OVF_BIT]   = ovf_q;
    status_frame[STAT_UDF_BIT]   = udf_q;
    status_frame[STAT_FULL_BIT]  = (count_q == SIZE_C);
    status_frame[STAT_EMPTY_BIT] = (count_q == 8'd0);
  end

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    tx_word_d  = tx_word_q;
    tx_frame_d = tx_frame_q;
    count_d    = count_q;
    stat_idx_d = stat_idx_q;
    ovf_d      = ovf_q;
    udf_d      = udf_q;
    en_d       = 1'b0;
    wr_d       = 1'b0;
    clr_d      = 1'b0;
    do_fetch   = 1'b0;
    if (cs_rise) begin
      state_d    = IDLE;
      byte_idx_d = '0;
      tx_frame_d = '0;
      stat_idx_d = '0;
      if (state_q == CLR_WAIT) begin
        clr_d   = 1'b1;
        count_d = 8'd0;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;
      end
    end else if (cs_fall) begin
      state_d    = CMD;
      byte_idx_d = '0;
      tx_frame_d = '0;
    end else if (frame_pulse) begin
      case (state_q)
        CMD: begin
          tx_frame_d = '0;
          case (rx_data[7:0])
            OP_WRITE:  state_d = WR_COLLECT;
            OP_READ: begin
              state_d  = RD_STREAM;
              do_fetch = 1'b1;
            end
            OP_STATUS: begin
              state_d    = STAT;
              stat_idx_d = '0;
              tx_frame_d = status_frame;
            end
            OP_CLEAR:  state_d = CLR_WAIT;
            default:   state_d = DISCARD;
          endcase
        end
        WR_COLLECT: begin
          word_d = (word_q << FRAME_WIDTH) | DATA_WIDTH'(rx_data);
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            if (count_q < SIZE_C) begin
              en_d    = 1'b1;
              wr_d    = 1'b1;
              count_d = count_q + 8'd1;
            end else begin
              ovf_d = 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
        RD_STREAM: begin
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            do_fetch   = 1'b1;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            tx_frame_d = byte_shift[DATA_WIDTH-1 -: FRAME_WIDTH];
          end
        end
        STAT: begin
          tx_frame_d = '0;
          if (stat_idx_q == 2'd0) begin
            tx_frame_d = FRAME_WIDTH'(count_q);
            stat_idx_d = 2'd1;
          end else if (stat_idx_q == 2'd1) begin
            ovf_d      = 1'b0;
            udf_d      = 1'b0;
            stat_idx_d = 2'd2;
          end
        end
        default: ;
      endcase
    end
    if (do_fetch) begin
      if (count_q != 8'd0) begin
        tx_word_d = sorted_data;
        en_d      = 1'b1;
        count_d   = count_q - 8'd1;
      end else begin
        tx_word_d = '0;
        udf_d     = 1'b1;
      end
      tx_frame_d = tx_word_d[DATA_WIDTH-1 -: FRAME_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      word_q     <= '0;
      tx_word_q  <= '0;
      tx_frame_q <= '0;
      count_q    <= 8'd0;
      stat_idx_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      en_q       <= 1'b0;
      wr_q       <= 1'b0;
      clr_q      <= 1'b0;
      cs_meta_q  <= 1'b1;
      cs_s_q     <= 1'b1;
      cs_prev_q  <= 1'b1;
      flag_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      tx_word_q  <= tx_word_d;
      tx_frame_q <= tx_frame_d;
      count_q    <= count_d;
      stat_idx_q <= stat_idx_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      en_q       <= en_d;
      wr_q       <= wr_d;
      clr_q      <= clr_d;
      cs_meta_q  <= cs;
      cs_s_q     <= cs_meta_q;
      cs_prev_q  <= cs_s_q;
      flag_q     <= new_flag;
    end
  end

  assign word_count = count_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;

endmodule

// File: tb/tb_spi_sort_bridge.sv
// Bench for spi_sort_bridge (16-bit words, depth 4): queue-based reference model plus literal expectations.
module tb_spi_sort_bridge;

  logic       clk = 1'b0;
  logic       reset, sck, mosi, cs, miso;
  logic [7:0] word_count;
  logic       overflow, underflow;

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int rd_pulses = 0;
  bit chk_en = 1'b0;

  logic [15:0] m_q[$];
  bit          m_ovf = 1'b0;
  bit          m_udf = 1'b0;
  logic [7:0]  txq[$];
  logic [7:0]  rx_log[$];

  spi_sort_bridge #(.FRAME_WIDTH(8), .DATA_WIDTH(16), .SIZE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .mosi      (mosi),
    .cs        (cs),
    .miso      (miso),
    .word_count(word_count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (dut.en_q) begin
      if (dut.wr_q) wr_pulses++;
      else          rd_pulses++;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        chk("word_count", {24'd0, word_count}, m_q.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("underflow", {31'd0, underflow}, {31'd0, m_udf});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic m_insert(input logic [15:0] w);
    int p;
    if (m_q.size() >= 4) begin
      m_ovf = 1'b1;
    end else begin
      p = 0;
      while (p < m_q.size() && m_q[p] <= w) p++;
      m_q.insert(p, w);
    end
  endtask

  task automatic m_fetch(output logic [15:0] t);
    if (m_q.size() > 0) begin
      t = m_q.pop_front();
    end else begin
      t = 16'h0000;
      m_udf = 1'b1;
    end
  endtask

  task automatic spi_frame(input logic [7:0] tx, output logic [7:0] rx);
    for (int b = 7; b >= 0; b--) begin
      mosi = tx[b];
      #50 sck = 1'b1;
      rx[b] = miso;
      #50 sck = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [7:0] fr[$]);
    logic [7:0]  op, exp, got, sb, cnt_snap;
    logic [15:0] wacc, txw;
    op = fr[0]; wacc = '0; txw = '0; sb = '0; cnt_snap = '0;
    rx_log.delete();
    @(negedge clk);
    cs = 1'b0;
    #100;
    for (int i = 0; i < fr.size(); i++) begin
      exp = 8'h00;
      if (op == 8'h02 && i > 0) exp = ((i - 1) % 2 == 0) ? txw[15:8] : txw[7:0];
      if (op == 8'h03 && i == 1) exp = sb;
      if (op == 8'h03 && i == 2) exp = cnt_snap;
      chk_en = 1'b0;
      spi_frame(fr[i], got);
      rx_log.push_back(got);
      chk($sformatf("miso op %02h frame %0d", op, i), {24'd0, got}, {24'd0, exp});
      #150;
      if (i == 0) begin
        if (op == 8'h02) m_fetch(txw);
        if (op == 8'h03) sb = {m_ovf, m_udf, (m_q.size() == 4), (m_q.size() == 0), 4'b0000};
      end else if (op == 8'h01) begin
        wacc = {wacc[7:0], fr[i]};
        if (i % 2 == 0) m_insert(wacc);
      end else if (op == 8'h02) begin
        if (i % 2 == 0) m_fetch(txw);
      end else if (op == 8'h03) begin
        if (i == 1) cnt_snap = 8'(m_q.size());
        if (i == 2) begin
          m_ovf = 1'b0;
          m_udf = 1'b0;
        end
      end
      chk_en = 1'b1;
    end
    chk_en = 1'b0;
    cs = 1'b1;
    #150;
    if (op == 8'h04) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    chk_en = 1'b1;
  endtask

  initial begin
    logic [7:0] g;
    reset = 1'b1; sck = 1'b0; mosi = 1'b0; cs = 1'b1;
    #20;
    chk("reset word_count", {24'd0, word_count}, 32'd0);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    chk("reset underflow", {31'd0, underflow}, 32'd0);
    chk("reset miso", {31'd0, miso}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #50;
    chk_en = 1'b1;

    txq = {8'h01, 8'h12, 8'h34, 8'h00, 8'h05};
    run_txn(txq);
    chk("write2 count", {24'd0, word_count}, 32'd2);
    chk("write2 overflow", {31'd0, overflow}, 32'd0);
    chk("write2 enables", wr_pulses, 32'd2);

    txq = {8'h01, 8'h04, 8'h00};
    run_txn(txq);
    txq = {8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_txn(txq);
    txq = {8'h00, 8'h00, 8'h05, 8'h04, 8'h00, 8'h12, 8'h34};
    for (int i = 0; i < 7; i++) chk($sformatf("read3 byte %0d", i), {24'd0, rx_log[i]}, {24'd0, txq[i]});
    chk("read3 count", {24'd0, word_count}, 32'd0);
    chk("read3 underflow", {31'd0, underflow}, 32'd1);
    chk("read3 enables", rd_pulses, 32'd3);

    txq = {8'h03, 8'h00, 8'h00};
    run_txn(txq);
    chk("status udf byte", {24'd0, rx_log[1]}, 32'h50);
    chk("status udf cleared", {31'd0, underflow}, 32'd0);

    txq = {8'h01};
    foreach (txq[i]) ;
    for (int w = 0; w < 5; w++) begin
      txq.push_back(8'h00);
      txq.push_back((w == 0) ? 8'h03 : (w == 1) ? 8'h01 : (w == 2) ? 8'h02 : (w == 3) ? 8'h04 : 8'h09);
    end
    run_txn(txq);
    chk("full count", {24'd0, word_count}, 32'd4);
    chk("full overflow", {31'd0, overflow}, 32'd1);

    txq = {8'h03, 8'h00, 8'h00, 8'h00};
    run_txn(txq);
    chk("status full byte", {24'd0, rx_log[1]}, 32'hA0);
    chk("status count byte", {24'd0, rx_log[2]}, 32'h04);
    chk("status trailing byte", {24'd0, rx_log[3]}, 32'h00);
    chk("status ovf cleared", {31'd0, overflow}, 32'd0);

    txq = {8'h02};
    run_txn(txq);
    chk("read entry pop count", {24'd0, word_count}, 32'd3);

    txq = {8'h04};
    run_txn(txq);
    chk("clear count", {24'd0, word_count}, 32'd0);

    txq = {8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_txn(txq);
    chk("empty read underflow", {31'd0, underflow}, 32'd1);
    chk("empty read byte", {24'd0, rx_log[2]}, 32'h00);

    txq = {8'h01, 8'hAB};
    run_txn(txq);
    chk("partial write count", {24'd0, word_count}, 32'd0);
    txq = {8'h01, 8'h00, 8'h11};
    run_txn(txq);
    chk("aligned write count", {24'd0, word_count}, 32'd1);

    txq = {8'h07, 8'h55, 8'h66};
    run_txn(txq);
    chk("discard count", {24'd0, word_count}, 32'd1);

    txq = {8'h01, 8'h00, 8'h22};
    run_txn(txq);
    chk_en = 1'b0;
    @(negedge clk);
    cs = 1'b0;
    #100;
    spi_frame(8'h02, g);
    #150;
    spi_frame(8'hFF, g);
    chk("pre-reset count", {24'd0, word_count}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid-read reset count", {24'd0, word_count}, 32'd0);
    chk("mid-read reset overflow", {31'd0, overflow}, 32'd0);
    chk("mid-read reset underflow", {31'd0, underflow}, 32'd0);
    chk("mid-read reset miso", {31'd0, miso}, 32'd0);
    m_q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
    cs = 1'b1;
    #99;
    @(negedge clk);
    reset = 1'b0;
    #100;
    chk_en = 1'b1;
    txq = {8'h01, 8'h00, 8'h33};
    run_txn(txq);
    chk("post-reset write count", {24'd0, word_count}, 32'd1);

    chk_en = 1'b0;
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
